// File: rtl/vadj_seq_pkg.sv
`default_nettype none
// ============================================================================
// vadj_seq_pkg : state codes, level codes and counter sizing for the VADJ
// power sequencer.                                           Rev 1.0
// ============================================================================
package vadj_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_LVL  = 3'd1,
    ST_RAMP     = 3'd2,
    ST_STABLE   = 3'd3,
    ST_RUN      = 3'd4,
    ST_SHUTDOWN = 3'd5,
    ST_FAULT    = 3'd6
  } vadj_state_e;

  localparam logic [1:0] LVL_DEFAULT = 2'b11;

  // The counter is loaded with N-1, so $clog2 of the largest N always fits.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vadj_pgood_sync.sv
`default_nettype none
// ============================================================================
// vadj_pgood_sync : two-flop synchroniser for the regulator power-good pin,
// resets low.                                                Rev 1.0
// ============================================================================
module vadj_pgood_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/vadj_power_sequencer.sv
`default_nettype none
// ============================================================================
// vadj_power_sequencer : VADJ rail bring-up / shutdown sequencer with
// power-good qualification. Define VADJ_RETRY_EN for automatic fault retry.
// Rev 1.0
// ============================================================================
module vadj_power_sequencer
  import vadj_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES     = 131072,
  parameter int PG_TIMEOUT_CYCLES = 1000000,
  parameter int PG_STABLE_CYCLES  = 1024,
  parameter int DISCHARGE_CYCLES  = 65536,
  parameter int MAX_RETRY         = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_enable,
  input  logic [1:0] i_lvl_sel,
  input  logic       i_clr_fault,
  input  logic       i_pgood,
  output logic       o_lvl_adj0,
  output logic       o_lvl_adj1,
  output logic       o_auto_vadj,
  output logic       o_vadj_en,
  output logic       or_rstn,
  output logic       o_fault,
  output logic       o_busy,
  output logic [2:0] o_state
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, PG_TIMEOUT_CYCLES,
                                   PG_STABLE_CYCLES, DISCHARGE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(PG_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LD  = CNT_W'(PG_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISCH_LD   = CNT_W'(DISCHARGE_CYCLES - 1);

  vadj_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lvl_q, lvl_d;
  logic             rail_q, adc_rstn_q, fault_q, busy_q;
  logic             w_fault_d;
  logic             w_pg_s;

  vadj_pgood_sync u_pgood_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (i_pgood),
    .q_o  (w_pg_s)
  );

`ifdef VADJ_RETRY_EN
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0] retry_q, retry_d;
`else
  logic w_unused_retry;
  assign w_unused_retry = (MAX_RETRY != 0);
`endif

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
`ifdef VADJ_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          lvl_d   = i_lvl_sel;
          state_d = ST_SET_LVL;
        end
      end
      ST_SET_LVL: begin
        if (!i_enable)         state_d = ST_SHUTDOWN;
        else if (cnt_q == '0)  state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (!i_enable)         state_d = ST_SHUTDOWN;
        else if (w_pg_s)       state_d = ST_STABLE;
        else if (cnt_q == '0)  state_d = ST_FAULT;
      end
      ST_STABLE: begin
        if (!i_enable)         state_d = ST_SHUTDOWN;
        else if (!w_pg_s)      state_d = ST_RAMP;
        else if (cnt_q == '0) begin
          state_d = ST_RUN;
`ifdef VADJ_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ST_RUN: begin
        if (!w_pg_s)                                state_d = ST_FAULT;
        else if (!i_enable || (i_lvl_sel != lvl_q)) state_d = ST_SHUTDOWN;
      end
      ST_SHUTDOWN: begin
        if (cnt_q == '0)       state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (i_clr_fault) begin
          state_d = ST_SHUTDOWN;
`ifdef VADJ_RETRY_EN
          retry_d = '0;
        end else if (retry_q < RTY_MAX) begin
          state_d = ST_SHUTDOWN;
          retry_d = retry_q + RTY_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state entry reloads the shared down-counter.
    if (state_d != state_q) begin
      unique case (state_d)
        ST_SET_LVL:  cnt_d = SETTLE_LD;
        ST_RAMP:     cnt_d = TIMEOUT_LD;
        ST_STABLE:   cnt_d = STABLE_LD;
        ST_SHUTDOWN: cnt_d = DISCH_LD;
        default:     cnt_d = '0;
      endcase
    end
  end

`ifdef VADJ_RETRY_EN
  assign w_fault_d = (state_d == ST_FAULT) && (retry_d == RTY_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`else
  assign w_fault_d = (state_d == ST_FAULT);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lvl_q      <= LVL_DEFAULT;
      rail_q     <= 1'b0;
      adc_rstn_q <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      rail_q     <= state_d inside {ST_RAMP, ST_STABLE, ST_RUN};
      adc_rstn_q <= (state_d == ST_RUN);
      fault_q    <= w_fault_d;
      busy_q     <= state_d inside {ST_SET_LVL, ST_RAMP, ST_STABLE, ST_SHUTDOWN};
    end
  end

  assign o_lvl_adj0  = lvl_q[0];
  assign o_lvl_adj1  = lvl_q[1];
  assign o_auto_vadj = rail_q;
  assign o_vadj_en   = rail_q;
  assign or_rstn     = adc_rstn_q;
  assign o_fault     = fault_q;
  assign o_busy      = busy_q;
  assign o_state     = state_q;

endmodule
`default_nettype wire
